// File: rtl/i2c_reg_bank_ctrl.sv
// rtl/i2c_reg_bank_ctrl.sv - I2C-addressed register bank with pointer auto-increment and tx prefetch stall
// Optional pointer wrap-around build: define I2C_REG_BANK_PTR_WRAP_EN.
module i2c_reg_bank_ctrl #(
  parameter logic [6:0] I2C_ADDRESS = 7'h42,
  parameter int         NUM_REGS    = 16,
  parameter int         PTR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       i2c_addr_rw,
  input  logic             i2c_addr_rw_valid_stb,
  input  logic [7:0]       i2c_data_rx,
  input  logic             i2c_data_rx_valid_stb,
  output logic [7:0]       i2c_data_tx,
  input  logic             i2c_data_tx_loaded_stb,
  input  logic             i2c_data_tx_done_stb,
  input  logic             i2c_error_stb,
  output logic             stall,
  input  logic             local_wr_en,
  input  logic [PTR_W-1:0] local_wr_addr,
  input  logic [7:0]       local_wr_data,
  output logic             local_wr_collision_stb,
  input  logic [PTR_W-1:0] local_rd_addr,
  output logic [7:0]       local_rd_data,
  output logic             reg_wr_stb,
  output logic [PTR_W-1:0] reg_wr_addr,
  output logic [7:0]       reg_wr_data,
  output logic [PTR_W-1:0] ptr
);

  localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int               DEPTH      = 1 << IDX_W;
  localparam logic [PTR_W:0]   NUM_REGS_X = (PTR_W+1)'(NUM_REGS);
  localparam logic [PTR_W-1:0] LAST_REG   = PTR_W'(NUM_REGS - 1);
  localparam logic [PTR_W-1:0] PTR_MAX    = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_PTR, ST_WRITE, ST_READ} state_t;

  state_t     state, state_next;
  logic [7:0] regs [DEPTH];
  logic       ptr_load, ptr_inc, i2c_wr, stall_trig, stall_hold;
  logic       addr_match, local_wr_ok, collision;

  // The loaded strobe carries no information this controller needs.
  logic unused_tx_loaded;
  assign unused_tx_loaded = i2c_data_tx_loaded_stb;

  function automatic logic in_range(input logic [PTR_W-1:0] a);
    return {1'b0, a} < NUM_REGS_X;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
`ifdef I2C_REG_BANK_PTR_WRAP_EN
    if (p == LAST_REG || p == PTR_MAX) return '0;
    else                               return p + PTR_W'(1);
`else
    if (p == PTR_MAX) return p;
    else              return p + PTR_W'(1);
`endif
  endfunction

  assign addr_match  = (i2c_addr_rw[7:1] == I2C_ADDRESS);
  assign local_wr_ok = local_wr_en && in_range(local_wr_addr);
  assign collision   = local_wr_ok && i2c_wr && (local_wr_addr == ptr);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i2c_error_stb) begin
      state_next = ST_IDLE;
    end else if (i2c_addr_rw_valid_stb) begin
      if (!addr_match)        state_next = ST_IDLE;
      else if (i2c_addr_rw[0]) state_next = ST_READ;
      else                    state_next = ST_PTR;
    end else if (state == ST_PTR && i2c_data_rx_valid_stb) begin
      state_next = ST_WRITE;
    end
  end

  // Address strobes take priority over data strobes; an error masks everything.
  always_comb begin
    ptr_load   = 1'b0;
    ptr_inc    = 1'b0;
    i2c_wr     = 1'b0;
    stall_trig = 1'b0;
    if (!i2c_error_stb) begin
      if (i2c_addr_rw_valid_stb) begin
        stall_trig = addr_match && i2c_addr_rw[0];
      end else begin
        case (state)
          ST_PTR:   ptr_load = i2c_data_rx_valid_stb;
          ST_WRITE: begin
            ptr_inc = i2c_data_rx_valid_stb;
            i2c_wr  = i2c_data_rx_valid_stb && in_range(ptr);
          end
          ST_READ: begin
            ptr_inc    = i2c_data_tx_done_stb;
            stall_trig = i2c_data_tx_done_stb;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        ptr <= '0;
    else if (ptr_load) ptr <= i2c_data_rx;
    else if (ptr_inc)  ptr <= ptr_next(ptr);
  end

  // I2C write is applied last so it overrides a colliding fabric write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (local_wr_ok) regs[local_wr_addr[IDX_W-1:0]] <= local_wr_data;
      if (i2c_wr)      regs[ptr[IDX_W-1:0]]           <= i2c_data_rx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_wr_stb             <= 1'b0;
      reg_wr_addr            <= '0;
      reg_wr_data            <= '0;
      local_wr_collision_stb <= 1'b0;
    end else begin
      reg_wr_stb             <= i2c_wr;
      local_wr_collision_stb <= collision;
      if (i2c_wr) begin
        reg_wr_addr <= ptr;
        reg_wr_data <= i2c_data_rx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i2c_data_tx   <= '0;
      local_rd_data <= '0;
    end else begin
      i2c_data_tx   <= in_range(ptr)           ? regs[ptr[IDX_W-1:0]]           : 8'hFF;
      local_rd_data <= in_range(local_rd_addr) ? regs[local_rd_addr[IDX_W-1:0]] : 8'hFF;
    end
  end

  // Stall covers the trigger cycle plus the cycle in which i2c_data_tx refreshes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall      <= 1'b0;
      stall_hold <= 1'b0;
    end else if (stall_trig) begin
      stall      <= 1'b1;
      stall_hold <= 1'b1;
    end else if (stall_hold) begin
      stall_hold <= 1'b0;
    end else begin
      stall <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_reg_bank_ctrl.sv
// tb/tb_i2c_reg_bank_ctrl.sv - directed self-checking bench for i2c_reg_bank_ctrl
module tb_i2c_reg_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i2c_addr_rw;
  logic       i2c_addr_rw_valid_stb;
  logic [7:0] i2c_data_rx;
  logic       i2c_data_rx_valid_stb;
  logic [7:0] i2c_data_tx;
  logic       i2c_data_tx_loaded_stb;
  logic       i2c_data_tx_done_stb;
  logic       i2c_error_stb;
  logic       stall;
  logic       local_wr_en;
  logic [7:0] local_wr_addr;
  logic [7:0] local_wr_data;
  logic       local_wr_collision_stb;
  logic [7:0] local_rd_addr;
  logic [7:0] local_rd_data;
  logic       reg_wr_stb;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic [7:0] ptr;

  int checks = 0;
  int errors = 0;

  i2c_reg_bank_ctrl #(.I2C_ADDRESS(7'h42), .NUM_REGS(16), .PTR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i2c_addr_rw(i2c_addr_rw), .i2c_addr_rw_valid_stb(i2c_addr_rw_valid_stb),
    .i2c_data_rx(i2c_data_rx), .i2c_data_rx_valid_stb(i2c_data_rx_valid_stb),
    .i2c_data_tx(i2c_data_tx), .i2c_data_tx_loaded_stb(i2c_data_tx_loaded_stb),
    .i2c_data_tx_done_stb(i2c_data_tx_done_stb), .i2c_error_stb(i2c_error_stb),
    .stall(stall), .local_wr_en(local_wr_en), .local_wr_addr(local_wr_addr),
    .local_wr_data(local_wr_data), .local_wr_collision_stb(local_wr_collision_stb),
    .local_rd_addr(local_rd_addr), .local_rd_data(local_rd_data),
    .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .ptr(ptr)
  );

  always #5 clk = ~clk;

  // Each strobe task leaves the caller at the falling edge right after the sampling edge.
  task automatic send_addr(input logic [7:0] a);
    @(negedge clk); i2c_addr_rw = a; i2c_addr_rw_valid_stb = 1'b1;
    @(negedge clk); i2c_addr_rw_valid_stb = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d);
    @(negedge clk); i2c_data_rx = d; i2c_data_rx_valid_stb = 1'b1;
    @(negedge clk); i2c_data_rx_valid_stb = 1'b0;
  endtask

  task automatic send_tx_done();
    @(negedge clk); i2c_data_tx_loaded_stb = 1'b1; i2c_data_tx_done_stb = 1'b1;
    @(negedge clk); i2c_data_tx_loaded_stb = 1'b0; i2c_data_tx_done_stb = 1'b0;
  endtask

  task automatic local_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); local_wr_en = 1'b1; local_wr_addr = a; local_wr_data = d;
    @(negedge clk); local_wr_en = 1'b0;
  endtask

  task automatic local_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk); local_rd_addr = a;
    @(negedge clk); d = local_rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ptr !== 8'h00) begin errors++; $display("FAIL reset_ptr: got %h expected 00", ptr); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (i2c_data_tx !== 8'h00) begin errors++; $display("FAIL reset_tx: got %h expected 00", i2c_data_tx); end
    checks++; if (local_rd_data !== 8'h00) begin errors++; $display("FAIL reset_local_rd: got %h expected 00", local_rd_data); end
    checks++; if ({reg_wr_stb, local_wr_collision_stb} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {reg_wr_stb, local_wr_collision_stb}); end
    checks++; if ({reg_wr_addr, reg_wr_data} !== 16'h0000) begin errors++; $display("FAIL reset_wr_info: got %h expected 0000", {reg_wr_addr, reg_wr_data}); end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    logic [7:0] d;
    send_addr(8'h84);
    send_rx(8'h03);
    checks++; if (ptr !== 8'h03) begin errors++; $display("FAIL wr_ptr_load: got %h expected 03", ptr); end
    checks++; if (reg_wr_stb !== 1'b0) begin errors++; $display("FAIL wr_no_stb_on_ptr: got %b expected 0", reg_wr_stb); end
    send_rx(8'hA5);
    checks++; if ({reg_wr_stb, reg_wr_addr, reg_wr_data} !== {1'b1, 8'h03, 8'hA5}) begin errors++; $display("FAIL wr_stb1: got %b/%h/%h expected 1/03/a5", reg_wr_stb, reg_wr_addr, reg_wr_data); end
    send_rx(8'h5A);
    checks++; if ({reg_wr_stb, reg_wr_addr, reg_wr_data} !== {1'b1, 8'h04, 8'h5A}) begin errors++; $display("FAIL wr_stb2: got %b/%h/%h expected 1/04/5a", reg_wr_stb, reg_wr_addr, reg_wr_data); end
    @(negedge clk);
    checks++; if (reg_wr_stb !== 1'b0) begin errors++; $display("FAIL wr_stb_pulse: got %b expected 0", reg_wr_stb); end
    checks++; if (ptr !== 8'h05) begin errors++; $display("FAIL wr_ptr_end: got %h expected 05", ptr); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wr_stall: got %b expected 0", stall); end
    local_read(8'h03, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL wr_reg3: got %h expected a5", d); end
    local_read(8'h04, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL wr_reg4: got %h expected 5a", d); end
  endtask

  task automatic test_mismatch();
    logic [7:0] d;
    send_addr(8'h86);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mm_stall_addr: got %b expected 0", stall); end
    send_rx(8'h01);
    checks++; if (ptr !== 8'h05) begin errors++; $display("FAIL mm_ptr: got %h expected 05", ptr); end
    send_rx(8'hEE);
    checks++; if ({reg_wr_stb, stall} !== 2'b00) begin errors++; $display("FAIL mm_stb_stall: got %b expected 00", {reg_wr_stb, stall}); end
    send_addr(8'h87);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mm_stall_read: got %b expected 0", stall); end
    local_read(8'h01, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL mm_reg1: got %h expected 00", d); end
  endtask

  task automatic test_read();
    local_write(8'h02, 8'h11);
    local_write(8'h03, 8'h22);
    send_addr(8'h84);
    send_rx(8'h02);
    send_addr(8'h85);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rd_stall_a0: got %b expected 1", stall); end
    @(negedge clk);
    checks++; if ({stall, i2c_data_tx} !== {1'b1, 8'h11}) begin errors++; $display("FAIL rd_a1: got %b/%h expected 1/11", stall, i2c_data_tx); end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd_stall_a2: got %b expected 0", stall); end
    send_tx_done();
    checks++; if ({stall, ptr} !== {1'b1, 8'h03}) begin errors++; $display("FAIL rd_d0: got %b/%h expected 1/03", stall, ptr); end
    @(negedge clk);
    checks++; if ({stall, i2c_data_tx} !== {1'b1, 8'h22}) begin errors++; $display("FAIL rd_d1: got %b/%h expected 1/22", stall, i2c_data_tx); end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd_stall_d2: got %b expected 0", stall); end
    send_tx_done();
    repeat (2) @(negedge clk);
    checks++; if ({stall, ptr} !== {1'b0, 8'h04}) begin errors++; $display("FAIL rd_end: got %b/%h expected 0/04", stall, ptr); end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    send_addr(8'h84);
    send_rx(8'h07);
    @(negedge clk);
    i2c_data_rx = 8'hC3; i2c_data_rx_valid_stb = 1'b1;
    local_wr_en = 1'b1; local_wr_addr = 8'h07; local_wr_data = 8'h3C;
    @(negedge clk);
    i2c_data_rx_valid_stb = 1'b0; local_wr_en = 1'b0;
    checks++; if ({local_wr_collision_stb, reg_wr_stb} !== 2'b11) begin errors++; $display("FAIL col_stb: got %b expected 11", {local_wr_collision_stb, reg_wr_stb}); end
    @(negedge clk);
    checks++; if (local_wr_collision_stb !== 1'b0) begin errors++; $display("FAIL col_pulse: got %b expected 0", local_wr_collision_stb); end
    local_read(8'h07, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL col_reg7: got %h expected c3", d); end
    local_write(8'h09, 8'h77);
    checks++; if (local_wr_collision_stb !== 1'b0) begin errors++; $display("FAIL col_none: got %b expected 0", local_wr_collision_stb); end
    local_read(8'h09, d);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL local_reg9: got %h expected 77", d); end
    local_write(8'd20, 8'hAB);
    local_read(8'd20, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL local_oor: got %h expected ff", d); end
  endtask

  task automatic test_boundary();
    logic [7:0] d;
    logic [7:0] exp_ptr1, exp_ptr2, exp_reg0, exp_tx, exp_sat;
    logic       exp_stb2;
`ifdef I2C_REG_BANK_PTR_WRAP_EN
    exp_ptr1 = 8'h00; exp_ptr2 = 8'h01; exp_stb2 = 1'b1; exp_reg0 = 8'hB2; exp_tx = 8'h00; exp_sat = 8'h00;
`else
    exp_ptr1 = 8'h10; exp_ptr2 = 8'h11; exp_stb2 = 1'b0; exp_reg0 = 8'h00; exp_tx = 8'hFF; exp_sat = 8'hFF;
`endif
    send_addr(8'h84);
    send_rx(8'h0F);
    send_rx(8'hB1);
    checks++; if ({reg_wr_stb, ptr} !== {1'b1, exp_ptr1}) begin errors++; $display("FAIL bnd_first: got %b/%h expected 1/%h", reg_wr_stb, ptr, exp_ptr1); end
    send_rx(8'hB2);
    checks++; if ({reg_wr_stb, ptr} !== {exp_stb2, exp_ptr2}) begin errors++; $display("FAIL bnd_second: got %b/%h expected %b/%h", reg_wr_stb, ptr, exp_stb2, exp_ptr2); end
    local_read(8'h0F, d);
    checks++; if (d !== 8'hB1) begin errors++; $display("FAIL bnd_reg15: got %h expected b1", d); end
    local_read(8'h00, d);
    checks++; if (d !== exp_reg0) begin errors++; $display("FAIL bnd_reg0: got %h expected %h", d, exp_reg0); end
    send_addr(8'h85);
    repeat (2) @(negedge clk);
    checks++; if (i2c_data_tx !== exp_tx) begin errors++; $display("FAIL bnd_read: got %h expected %h", i2c_data_tx, exp_tx); end
    send_addr(8'h84);
    send_rx(8'hFE);
    send_rx(8'h00);
    checks++; if ({reg_wr_stb, ptr} !== {1'b0, 8'hFF}) begin errors++; $display("FAIL bnd_fe: got %b/%h expected 0/ff", reg_wr_stb, ptr); end
    send_rx(8'h00);
    checks++; if ({reg_wr_stb, ptr} !== {1'b0, exp_sat}) begin errors++; $display("FAIL bnd_ff: got %b/%h expected 0/%h", reg_wr_stb, ptr, exp_sat); end
  endtask

  task automatic test_error_reset();
    logic [7:0] d;
    send_addr(8'h84);
    send_rx(8'h05);
    @(negedge clk); i2c_error_stb = 1'b1;
    @(negedge clk); i2c_error_stb = 1'b0;
    checks++; if (ptr !== 8'h05) begin errors++; $display("FAIL err_ptr_kept: got %h expected 05", ptr); end
    send_rx(8'h99);
    checks++; if ({reg_wr_stb, ptr} !== {1'b0, 8'h05}) begin errors++; $display("FAIL err_idle: got %b/%h expected 0/05", reg_wr_stb, ptr); end
    local_read(8'h05, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL err_reg5: got %h expected 00", d); end
    send_addr(8'h85);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %b expected 1", stall); end
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    checks++; if ({stall, ptr, i2c_data_tx} !== {1'b0, 8'h00, 8'h00}) begin errors++; $display("FAIL rst_mid: got %b/%h/%h expected 0/00/00", stall, ptr, i2c_data_tx); end
    local_read(8'h03, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_reg3: got %h expected 00", d); end
    local_read(8'h07, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_reg7: got %h expected 00", d); end
    send_rx(8'h55);
    checks++; if ({reg_wr_stb, ptr, stall} !== {1'b0, 8'h00, 1'b0}) begin errors++; $display("FAIL rst_idle: got %b/%h/%b expected 0/00/0", reg_wr_stb, ptr, stall); end
  endtask

  initial begin
    rst_n = 1'b0;
    i2c_addr_rw = '0; i2c_addr_rw_valid_stb = 1'b0;
    i2c_data_rx = '0; i2c_data_rx_valid_stb = 1'b0;
    i2c_data_tx_loaded_stb = 1'b0; i2c_data_tx_done_stb = 1'b0; i2c_error_stb = 1'b0;
    local_wr_en = 1'b0; local_wr_addr = '0; local_wr_data = '0; local_rd_addr = '0;
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_collision();
    test_boundary();
    test_error_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
